// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks one active-low row at a time, debounces press
// and release on a slow scan tick, and reports the accepted key with a valid strobe.
module keypad_scan #(
  parameter int CLK_DIV        = 50000,
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic       clk_50mhz,
  input  logic       n_rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int            TW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [7:0]    DB_LAST   = 8'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    col_meta, col_s;
  logic [1:0]    row_idx, row_idx_nx;
  logic [1:0]    col_idx, col_idx_nx;
  logic [1:0]    low_col;
  logic [7:0]    deb_cnt, deb_cnt_nx, deb_inc;
  logic [3:0]    key_code_nx;
  logic          key_valid_nx, key_down_nx;

  assign tick    = (tick_cnt == TICK_LAST);
  assign deb_inc = deb_cnt + 8'd1;

  always_ff @(posedge clk_50mhz or negedge n_rst) begin
    if (!n_rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // Idle (pulled-up) level on reset so the first samples never look like a press.
  always_ff @(posedge clk_50mhz or negedge n_rst) begin
    if (!n_rst) begin
      col_meta <= 4'hF;
      col_s    <= 4'hF;
    end else begin
      col_meta <= col;
      col_s    <= col_meta;
    end
  end

  always_comb begin
    low_col = 2'd0;
    if (!col_s[0])      low_col = 2'd0;
    else if (!col_s[1]) low_col = 2'd1;
    else if (!col_s[2]) low_col = 2'd2;
    else                low_col = 2'd3;
  end

  always_ff @(posedge clk_50mhz or negedge n_rst) begin
    if (!n_rst) begin
      state     <= SCAN;
      row_idx   <= 2'd0;
      row       <= 4'b1110;
      col_idx   <= 2'd0;
      deb_cnt   <= 8'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      state     <= state_nx;
      row_idx   <= row_idx_nx;
      row       <= ~(4'b0001 << row_idx_nx);
      col_idx   <= col_idx_nx;
      deb_cnt   <= deb_cnt_nx;
      key_code  <= key_code_nx;
      key_valid <= key_valid_nx;
      key_down  <= key_down_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    row_idx_nx   = row_idx;
    col_idx_nx   = col_idx;
    deb_cnt_nx   = deb_cnt;
    key_code_nx  = key_code;
    key_valid_nx = 1'b0;
    key_down_nx  = key_down;
    if (tick) begin
      case (state)
        SCAN: begin
          if (col_s == 4'b1111) begin
            row_idx_nx = row_idx + 2'd1;
          end else begin
            col_idx_nx = low_col;
            // The SCAN sample already counts as the first low sample.
            if (DB_LAST == 8'd1) begin
              state_nx     = PRESSED;
              key_code_nx  = {row_idx, low_col};
              key_valid_nx = 1'b1;
              key_down_nx  = 1'b1;
              deb_cnt_nx   = 8'd0;
            end else begin
              deb_cnt_nx = 8'd1;
              state_nx   = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (!col_s[col_idx]) begin
            if (deb_inc == DB_LAST) begin
              state_nx     = PRESSED;
              key_code_nx  = {row_idx, col_idx};
              key_valid_nx = 1'b1;
              key_down_nx  = 1'b1;
              deb_cnt_nx   = 8'd0;
            end else begin
              deb_cnt_nx = deb_inc;
            end
          end else begin
            // Row is not advanced: the same row is resampled on the next tick.
            deb_cnt_nx = 8'd0;
            state_nx   = SCAN;
          end
        end
        PRESSED: begin
          if (col_s[col_idx]) begin
            if (deb_inc == DB_LAST) begin
              key_down_nx = 1'b0;
              deb_cnt_nx  = 8'd0;
              row_idx_nx  = row_idx + 2'd1;
              state_nx    = SCAN;
            end else begin
              deb_cnt_nx = deb_inc;
            end
          end else begin
            deb_cnt_nx = 8'd0;
          end
        end
        default: state_nx = SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Randomized bench for keypad_scan: a physical keypad matrix drives the columns and a
// tick-level behavioural model predicts row, key_code, key_down and key_valid every cycle.
module tb_keypad_scan;

  localparam int CLK_DIV = 4;
  localparam int DB      = 3;

  logic       clk_50mhz = 1'b0;
  logic       n_rst;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  int n_checks = 0;
  int n_errors = 0;
  int v_cnt    = 0;

  keypad_scan #(.CLK_DIV(CLK_DIV), .DEBOUNCE_TICKS(DB)) dut (
    .clk_50mhz(clk_50mhz),
    .n_rst    (n_rst),
    .col      (col),
    .row      (row),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down)
  );

  // ---------------- clock ----------------
  always #5 clk_50mhz = ~clk_50mhz;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Modes: 0 = looking for a key, 1 = confirming a press, 2 = key held.
  int         m_mode = 0;
  int         m_row  = 0;
  int         m_col  = 0;
  int         m_run  = 0;
  int         m_edge = 0;
  logic [3:0] m_code = 4'd0;
  bit         m_down = 1'b0;
  bit         m_valid = 1'b0;
  logic [3:0] h1 = 4'hF;
  logic [3:0] h2 = 4'hF;

  function automatic int lowest_low(input logic [3:0] c);
    for (int i = 0; i < 4; i++) if (!c[i]) return i;
    return 0;
  endfunction

  function automatic logic [3:0] keypad_cols(input logic [3:0] r, input logic [15:0] k);
    logic [3:0] c = 4'hF;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (!r[i] && k[i*4+j]) c[j] = 1'b0;
    return c;
  endfunction

  task automatic model_accept();
    m_mode  = 2;
    m_code  = 4'(m_row * 4 + m_col);
    m_valid = 1'b1;
    m_down  = 1'b1;
    m_run   = 0;
  endtask

  task automatic model_tick(input logic [3:0] cs);
    case (m_mode)
      0: if (cs == 4'hF) m_row = (m_row + 1) % 4;
         else begin
           m_col  = lowest_low(cs);
           m_run  = 1;
           m_mode = 1;
           if (m_run == DB) model_accept();
         end
      1: if (!cs[m_col]) begin
           m_run++;
           if (m_run == DB) model_accept();
         end else begin
           m_run  = 0;
           m_mode = 0;
         end
      default: if (cs[m_col]) begin
           m_run++;
           if (m_run == DB) begin
             m_down = 1'b0;
             m_run  = 0;
             m_row  = (m_row + 1) % 4;
             m_mode = 0;
           end
         end else m_run = 0;
    endcase
  endtask

  always @(posedge clk_50mhz or negedge n_rst) begin
    if (!n_rst) begin
      m_mode = 0; m_row = 0; m_col = 0; m_run = 0; m_edge = 0;
      m_code = 4'd0; m_down = 1'b0; m_valid = 1'b0; h1 = 4'hF; h2 = 4'hF;
    end else begin
      logic [3:0] cs;
      cs = h2;
      h2 = h1;
      h1 = col;
      m_valid = 1'b0;
      if (m_edge % CLK_DIV == CLK_DIV - 1) model_tick(cs);
      m_edge++;
    end
  end

  // ---------------- scoreboard (every cycle, away from the active edge) ----------------
  always @(negedge clk_50mhz) begin
    logic [3:0] one;
    one = 4'b0001;
    check("outputs", 16'({row, key_code, key_down, key_valid}),
          16'({~(one << m_row), m_code, m_down, m_valid}));
    if (key_valid) v_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic run(input int n, input logic [15:0] k, input bit bnc);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_50mhz);
      if (bnc && $urandom_range(0, 3) == 0) col = 4'hF;
      else col = keypad_cols(row, k);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] keys;
    logic [3:0]  v;
    bit          found;
    col   = 4'hF;
    n_rst = 1'b0;
    #23 n_rst = 1'b1;

    run(40, 16'h0000, 1'b0);

    run(60, 16'h0200, 1'b0);
    check("code9", 16'(key_code), 16'd9);
    check("down_held", 16'(key_down), 16'd1);
    run(40, 16'h0000, 1'b0);
    check("released", 16'(key_down), 16'd0);
    check("code_kept", 16'(key_code), 16'd9);

    @(posedge clk_50mhz);
    v_cnt = 0;
    run(80, 16'h0005, 1'b0);
    check("one_strobe", 16'(v_cnt), 16'd1);
    check("code0", 16'(key_code), 16'd0);
    run(40, 16'h0000, 1'b0);

    repeat (20) begin
      keys = 16'd1 << $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) keys = keys | (16'd1 << $urandom_range(0, 15));
      run($urandom_range(4, 70), keys, 1'($urandom_range(0, 1)));
      run($urandom_range(4, 50), 16'h0000, 1'b0);
    end

    repeat (30) begin
      v = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 12)) begin
        @(negedge clk_50mhz);
        col = v;
      end
    end
    run(40, 16'h0000, 1'b0);

    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      run(1, 16'h0020, 1'b0);
      found = key_down;
    end
    check("down_wait", 16'(found), 16'd1);
    @(posedge clk_50mhz);
    #2 n_rst = 1'b0;
    #1;
    check("rst_row", 16'(row), 16'h000E);
    check("rst_code", 16'(key_code), 16'd0);
    check("rst_down", 16'(key_down), 16'd0);
    check("rst_valid", 16'(key_valid), 16'd0);
    #4 n_rst = 1'b1;
    run(80, 16'h0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
